// File: rtl/uart_pkg.sv
// uart_pkg: shared UART timing constants, divisor type and divisor calculation
package uart_pkg;
    localparam int UART_INCLK_FREQ = 50_000_000;
    localparam int UART_DEF_BAUD   = 115200;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DIV_WIDTH  = 16;
    typedef logic [UART_DIV_WIDTH-1:0] uart_div_t;
    function automatic int div_calc(input int freq, input int baud, input int os);
        return freq / (baud * os);
    endfunction
endpackage

// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: control and timing strobes between the baud generator and its UART clients
interface uart_baud_gen_if import uart_pkg::*; #(parameter int DivWidth = UART_DIV_WIDTH);
    logic                en;
    logic [DivWidth-1:0] div_in;
    logic                div_load;
    logic                rx_sync;
    logic                tx_tick;
    logic                rx_tick;
    logic                rx_mid;
    logic                oclk;
    logic [DivWidth-1:0] baud_div;
    logic                div_err;
    modport master (
        output en, div_in, div_load, rx_sync,
        input  tx_tick, rx_tick, rx_mid, oclk, baud_div, div_err
    );
    modport slave (
        input  en, div_in, div_load, rx_sync,
        output tx_tick, rx_tick, rx_mid, oclk, baud_div, div_err
    );
endinterface

// File: rtl/uart_prescaler.sv
// uart_prescaler: divide-by-(lim+1) counter feeding a modulo-Oversample phase counter
module uart_prescaler import uart_pkg::*; #(
    parameter  int DivWidth   = UART_DIV_WIDTH,
    parameter  int Oversample = UART_OVERSAMPLE,
    localparam int PhW        = $clog2(Oversample)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic [DivWidth-1:0] lim,
    output logic                wrap,
    output logic [PhW-1:0]      ph
);
    logic [DivWidth-1:0] cnt;
    assign wrap = en & (cnt == lim);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ph  <= '0;
        end else begin
            cnt <= (clr | ~en | wrap) ? '0 : cnt + 1'b1;
            ph  <= (clr | ~en) ? '0 : wrap ? ((ph == PhW'(Oversample - 1)) ? '0 : ph + 1'b1) : ph;
        end
    end
endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: loadable-divisor UART timebase with TX/RX ticks, RX mid-bit strobe and square bit clock
module uart_baud_gen import uart_pkg::*; #(
    parameter int InclkFreq  = UART_INCLK_FREQ,
    parameter int BandRate   = UART_DEF_BAUD,
    parameter int Oversample = UART_OVERSAMPLE,
    parameter int DivWidth   = UART_DIV_WIDTH,
    parameter int DefDiv     = div_calc(InclkFreq, BandRate, Oversample)
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_baud_gen_if.slave  bus
);
    localparam int PhW = $clog2(Oversample);
    logic [DivWidth-1:0] d;
    logic [DivWidth-1:0] lim;
    logic                load_ok;
    logic                tx_wrap;
    logic                rx_wrap;
    logic [PhW-1:0]      tx_ph;
    logic [PhW-1:0]      rx_ph;
    logic                oclk_q;
    logic                err_q;
    assign load_ok      = bus.div_load & (bus.div_in >= DivWidth'(2));
    assign lim          = d - 1'b1;
    assign bus.baud_div = d;
    assign bus.oclk     = oclk_q;
    assign bus.div_err  = err_q;
    assign bus.tx_tick  = tx_wrap & (tx_ph == PhW'(Oversample - 1));
    assign bus.rx_tick  = rx_wrap;
    assign bus.rx_mid   = rx_wrap & (rx_ph == PhW'(Oversample / 2 - 1));
    uart_prescaler #(.DivWidth(DivWidth), .Oversample(Oversample)) u_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (bus.en),
        .clr  (load_ok),
        .lim  (lim),
        .wrap (tx_wrap),
        .ph   (tx_ph)
    );
    // an accepted load clears everything, which already covers the rx_sync restart
    uart_prescaler #(.DivWidth(DivWidth), .Oversample(Oversample)) u_rx (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (bus.en),
        .clr  (load_ok | bus.rx_sync),
        .lim  (lim),
        .wrap (rx_wrap),
        .ph   (rx_ph)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d      <= DivWidth'(DefDiv);
            oclk_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            d      <= load_ok ? bus.div_in : d;
            err_q  <= bus.div_load & ~load_ok;
            oclk_q <= (~bus.en | load_ok) ? 1'b0 :
                      (tx_wrap & ((tx_ph == PhW'(Oversample / 2 - 1)) | (tx_ph == PhW'(Oversample - 1)))) ? ~oclk_q : oclk_q;
        end
    end
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed scoreboard bench for the UART timebase
module tb_uart_baud_gen;
    import uart_pkg::*;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   t0 = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_q[$];
    uart_baud_gen_if bus ();
    uart_baud_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic int rel();
        return cyc - t0;
    endfunction
    function automatic logic sel(input int which);
        return (which == 0) ? bus.tx_tick : (which == 1) ? bus.rx_tick : bus.rx_mid;
    endfunction
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic wait_to(input int n);
        while (rel() < n) @(negedge clk);
    endtask
    task automatic wait_pulse(input string tag, input int which, input int budget);
        int  exp;
        bit  hit;
        exp = exp_q.pop_front();
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            if (sel(which) === 1'b1) hit = 1;
            else @(negedge clk);
        end
        if (hit) begin
            check(tag, rel(), exp);
            @(negedge clk);
        end else begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed no pulse within %0d cycles expected at %0d", tag, budget, exp);
        end
    endtask
    task automatic load(input uart_div_t v);
        bus.div_in   = v;
        bus.div_load = 1'b1;
        @(negedge clk);
        bus.div_load = 1'b0;
    endtask
    initial begin
        int bad;
        rst_n        = 1'b0;
        bus.en       = 1'b1;
        bus.div_in   = '0;
        bus.div_load = 1'b0;
        bus.rx_sync  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_baud_div", bus.baud_div, 27);
        check("rst_ticks", {bus.tx_tick, bus.rx_tick, bus.rx_mid}, 0);
        check("rst_oclk_err", {bus.oclk, bus.div_err}, 0);
        rst_n = 1'b1;
        t0 = cyc;
        exp_q.push_back(26);
        wait_pulse("rx_first", 1, 100);
        exp_q.push_back(53);
        wait_pulse("rx_second", 1, 100);
        wait_to(215);
        check("oclk_215", bus.oclk, 0);
        wait_to(216);
        check("oclk_216", bus.oclk, 1);
        wait_to(431);
        check("oclk_431", bus.oclk, 1);
        exp_q.push_back(431);
        wait_pulse("tx_first", 0, 10);
        check("oclk_432", bus.oclk, 0);
        exp_q.push_back(863);
        wait_pulse("tx_second", 0, 500);
        wait_to(1000);
        bus.rx_sync = 1'b1;
        @(negedge clk);
        bus.rx_sync = 1'b0;
        exp_q.push_back(1027);
        wait_pulse("rx_sync_tick1", 1, 100);
        exp_q.push_back(1054);
        wait_pulse("rx_sync_tick2", 1, 100);
        exp_q.push_back(1216);
        wait_pulse("rx_mid_1", 2, 300);
        exp_q.push_back(1295);
        wait_pulse("tx_after_sync", 0, 200);
        exp_q.push_back(1648);
        wait_pulse("rx_mid_2", 2, 500);
        wait_to(2000);
        load(10);
        check("load10_baud_div", bus.baud_div, 10);
        exp_q.push_back(2010);
        wait_pulse("load10_rx", 1, 50);
        wait_to(2080);
        check("load10_oclk_2080", bus.oclk, 0);
        wait_to(2081);
        check("load10_oclk_2081", bus.oclk, 1);
        exp_q.push_back(2160);
        wait_pulse("load10_tx", 0, 200);
        check("load10_oclk_2161", bus.oclk, 0);
        wait_to(2241);
        check("load10_oclk_2241", bus.oclk, 1);
        wait_to(2500);
        load(1);
        check("load1_err", bus.div_err, 1);
        check("load1_baud_div", bus.baud_div, 10);
        @(negedge clk);
        check("load1_err_clear", bus.div_err, 0);
        wait_to(2600);
        load(0);
        check("load0_err", bus.div_err, 1);
        @(negedge clk);
        check("load0_err_clear", bus.div_err, 0);
        check("load0_baud_div", bus.baud_div, 10);
        exp_q.push_back(2610);
        wait_pulse("bad_load_rx", 1, 50);
        exp_q.push_back(2640);
        wait_pulse("bad_load_tx", 0, 100);
        wait_to(2700);
        load(27);
        check("load27_baud_div", bus.baud_div, 27);
        wait_to(3000);
        bus.en = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.tx_tick !== 1'b0 || bus.rx_tick !== 1'b0 || bus.rx_mid !== 1'b0) bad++;
            if (rel() > 3000 && bus.oclk !== 1'b0) bad++;
            @(negedge clk);
        end
        bus.en = 1'b1;
        check("en_low_quiet", bad, 0);
        exp_q.push_back(3076);
        wait_pulse("en_restart_rx", 1, 100);
        exp_q.push_back(3481);
        wait_pulse("en_restart_tx", 0, 500);
        wait_to(3600);
        load(10);
        wait_to(3700);
        check("pre_rst_oclk", bus.oclk, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_baud_div", bus.baud_div, 27);
        check("async_rst_outs", {bus.tx_tick, bus.rx_tick, bus.rx_mid, bus.oclk, bus.div_err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc;
        exp_q.push_back(26);
        wait_pulse("post_rst_rx", 1, 100);
        wait_to(215);
        check("post_rst_oclk_215", bus.oclk, 0);
        wait_to(216);
        check("post_rst_oclk_216", bus.oclk, 1);
        exp_q.push_back(431);
        wait_pulse("post_rst_tx", 0, 500);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
